divisor_prog: RTL

Runtime-programmable frequency divider driven by CLOCK_50. It generates a divided clock-enable waveform (square or single-cycle pulse) plus a one-cycle tick strobe for downstream FSMs and display scanners. A new divide value can be loaded at any time and is applied glitch-free at the next period boundary. It replaces fixed power-of-two dividers: any integer divide ratio from 2 to 2^CNT_W-1 is reachable.

---
 rtl/divisor_pkg.sv | 16 +
 rtl/divisor_prog.sv | 114 +++++++++++
 2 files changed

// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package divisor_pkg;

  // Board reference clock frequency
  localparam int unsigned CLK_HZ = 50000000;

  // Output waveform selection
  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Divide ratio that yields target_hz from the reference clock
  function automatic int unsigned hz_to_div(input int unsigned target_hz);
    return CLK_HZ / target_hz;
  endfunction

endpackage

// File: rtl/divisor_prog.sv
// Runtime-programmable frequency divider with glitch-free ratio updates.
// A load goes into a shadow register and is applied only when the period wraps.
module divisor_prog #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_value,
  input  logic             load,
  input  logic             mode_in,
  output logic             clock_modificado,
  output logic             tick,
  output logic             pending,
  output logic [CNT_W-1:0] count
);
  import divisor_pkg::*;

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
  logic             active_mode_q, active_mode_d;
  logic             shadow_mode_q, shadow_mode_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap, apply;
  logic [CNT_W-1:0] load_div;
  logic [CNT_W-1:0] half_div;

  // Period end detection and clamped load value
  always_comb begin
    wrap     = enable && (cnt_q == (active_div_q - One));
    apply    = wrap && pending_q;
    load_div = (div_value < MinDiv) ? MinDiv : div_value;
  end

  // Next-state: counter, shadow/active ratio handoff and pending flag
  always_comb begin
    cnt_d         = cnt_q;
    active_div_d  = active_div_q;
    active_mode_d = active_mode_q;
    shadow_div_d  = shadow_div_q;
    shadow_mode_d = shadow_mode_q;
    pending_d     = pending_q;

    if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + One;
    end

    // Apply uses the old shadow, so a load on the wrap cycle stays pending
    if (apply) begin
      active_div_d  = shadow_div_q;
      active_mode_d = shadow_mode_q;
    end

    if (load) begin
      shadow_div_d  = load_div;
      shadow_mode_d = mode_in;
      pending_d     = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  // Output next-state: square wave from the next count, or pulse on wrap
  always_comb begin
    // ceil(D/2) computed one bit wider so D = 2^CNT_W-1 does not overflow
    half_div  = CNT_W'(({1'b0, active_div_d} + {{CNT_W{1'b0}}, 1'b1}) >> 1);
    clk_out_d = clk_out_q;
    tick_d    = wrap;
    if (enable) begin
      if (active_mode_d == MODE_PULSE) begin
        clk_out_d = wrap;
      end else begin
        clk_out_d = (cnt_d < half_div);
      end
    end
  end

  // State register; reset aborts the current period and drops any pending load
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      active_div_q  <= DefDiv;
      active_mode_q <= MODE_SQUARE;
      shadow_div_q  <= DefDiv;
      shadow_mode_q <= MODE_SQUARE;
      pending_q     <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      active_div_q  <= active_div_d;
      active_mode_q <= active_mode_d;
      shadow_div_q  <= shadow_div_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q     <= pending_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
    end
  end

  assign count            = cnt_q;
  assign clock_modificado = clk_out_q;
  assign tick             = tick_q;
  assign pending          = pending_q;

endmodule
